comp_arb: RTL and testbench
===========================

COMP_ARB -- requirements
Module: comp_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'hFFFF, meaning WAIT-state cycles before a job is abandoned.
REQ-002 SHALL have CPMDMALLCLK, in, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have DMALLRSTENGINEACK, in, 1: reset, asynchronous and active-high.
REQ-004 SHALL have CHTXD in 64 ({ch1,ch0}), CHTXREM in 8, CHTXSOFN/CHTXEOFN/CHTXSOPN/CHTXEOPN/CHTXSRCRDYN in 2 each: requester LocalLink TX, active-low, bit i = channel i.
REQ-005 SHALL have CHTXDSTRDYN, out, 2: per-channel TX ready, active-low.
REQ-006 SHALL have ENGTXD out 32, ENGTXREM out 4, ENGTXSOFN/ENGTXEOFN/ENGTXSOPN/ENGTXEOPN/ENGTXSRCRDYN out 1 each, ENGTXDSTRDYN in 1: engine-side TX.
REQ-007 SHALL have ENGRXD in 32, ENGRXREM in 4, ENGRXSOFN/ENGRXEOFN/ENGRXSOPN/ENGRXEOPN/ENGRXSRCRDYN in 1 each, ENGRXDSTRDYN out 1: engine response.
REQ-008 SHALL have CHRXD out 32, CHRXREM out 4, CHRXSOFN/CHRXEOFN/CHRXSOPN/CHRXEOPN out 1 (shared to both channels), CHRXSRCRDYN out 2, CHRXDSTRDYN in 2.
REQ-009 SHALL have GNT out 2 (one-hot owner or 0) and TMO_ERR out 1 (one-cycle pulse).

Function
REQ-010 Beat = SRCRDYN=0 and DSTRDYN=0 on the same edge on a given link.
REQ-011 Request i = CHTXSRCRDYN[i]=0 and CHTXSOFN[i]=0.
REQ-012 FSM states IDLE, TX, WAIT, RX; one job (request frame plus response frame) owns the engine at a time.
REQ-013 IDLE: with requests, register grant, GNT one-hot, go TX next cycle; no beat is accepted from a requester in IDLE.
REQ-014 Arbitration round-robin: single request wins; both request, channel other than last_served wins; last_served updates on grant.
REQ-015 TX: ENGTX* = CHTX*[g] combinationally; CHTXDSTRDYN[g] = ENGTXDSTRDYN; non-granted CHTXDSTRDYN = 1; beat with EOFN=0 -> WAIT.
REQ-016 WAIT and RX: CHRX* = ENGRX*; CHRXSRCRDYN[g] = ENGRXSRCRDYN, other bit 1; ENGRXDSTRDYN = CHRXDSTRDYN[g].
REQ-017 WAIT: 16-bit counter cleared on entry, +1 per cycle; engine beat with SOFN=0 -> RX, or IDLE if EOFN=0 on the same beat.
REQ-018 WAIT: counter = TIMEOUT_CYCLES-1 with no SOF beat -> IDLE, TMO_ERR=1 for one cycle, GNT cleared; an SOF beat on that cycle wins (no timeout).
REQ-019 RX: engine beat with EOFN=0 -> IDLE, GNT cleared same edge; no timeout in RX.
REQ-020 IDLE and TX: ENGRXDSTRDYN = 0 in IDLE (discard stray response beats), 1 in TX; CHRXSRCRDYN = 2'b11.
REQ-021 Outside TX: ENGTXSRCRDYN=1, CHTXDSTRDYN=2'b11, ENGTX SOF/EOF/SOP/EOP = 1, ENGTXD/ENGTXREM = 0.
REQ-022 Latency: zero-cycle combinational forwarding in TX/WAIT/RX; one idle cycle between jobs (IDLE).

Reset
REQ-023 Reset asserted SHALL force immediately: state IDLE, GNT=0, TMO_ERR=0, counter 0, last_served=1 (ch0 wins first tie), CHTXDSTRDYN=2'b11, CHRXSRCRDYN=2'b11, ENGTXSRCRDYN=1, ENGRXDSTRDYN=0.
REQ-024 Reset mid-frame SHALL abort the job with no completion or TMO_ERR; requesters re-arbitrate from IDLE after release.

Structure
REQ-025 Shared package lzs_arb_pkg SHALL hold the state enum, NCH=2, LL_DW=32, LL_RW=4.
REQ-026 Round-robin grant logic SHALL be sub-module rr_arb2 (req[1:0], last, gnt[1:0]); the rest lives in comp_arb.

Verification
REQ-027 ch0 only: 4-beat frame, response SOF after 3 cycles, 2 beats -> GNT=01 throughout, ch0 gets both response beats, CHRXSRCRDYN[1]=1 always.
REQ-028 ch0 and ch1 both request from reset -> ch0 served first, then ch1; repeating both -> grants alternate 01,10,01.
REQ-029 TIMEOUT_CYCLES=8, engine silent -> TMO_ERR single pulse 8 cycles after WAIT entry, GNT=00, next request granted.
REQ-030 Engine drives ENGTXDSTRDYN=1 for 5 cycles mid-frame -> CHTXDSTRDYN[g]=1 for those cycles, no beat lost or duplicated.
REQ-031 Single-beat response (SOF and EOF together) -> state WAIT->IDLE in one beat, GNT cleared.
REQ-032 Reset pulse during TX beat 2 -> outputs at reset values in the same cycle, pending request re-granted after release.

Source files
------------

// File: rtl/lzs_arb_pkg.sv
// Shared types and constants for the two-channel compression-engine arbiter.
// The state enum is also what dbg_state_o carries out of comp_arb.
package lzs_arb_pkg;

  localparam int NCH   = 2;
  localparam int LL_DW = 32;
  localparam int LL_RW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RX   = 2'd3
  } arb_state_e;

  // A LocalLink beat completes when both active-low handshakes are low together.
  function automatic logic ll_beat(input logic src_rdy_n, input logic dst_rdy_n);
    return ~src_rdy_n & ~dst_rdy_n;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the
// channel that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/comp_arb.sv
// Shares one compression engine between two LocalLink requesters: one job
// (request frame out, response frame back) owns the engine at a time.
module comp_arb
  import lzs_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        CPMDMALLCLK,
  input  logic        DMALLRSTENGINEACK,
  // requester TX, bit i / slice i = channel i
  input  logic [63:0] CHTXD,
  input  logic [7:0]  CHTXREM,
  input  logic [1:0]  CHTXSOFN,
  input  logic [1:0]  CHTXEOFN,
  input  logic [1:0]  CHTXSOPN,
  input  logic [1:0]  CHTXEOPN,
  input  logic [1:0]  CHTXSRCRDYN,
  output logic [1:0]  CHTXDSTRDYN,
  // engine TX
  output logic [31:0] ENGTXD,
  output logic [3:0]  ENGTXREM,
  output logic        ENGTXSOFN,
  output logic        ENGTXEOFN,
  output logic        ENGTXSOPN,
  output logic        ENGTXEOPN,
  output logic        ENGTXSRCRDYN,
  input  logic        ENGTXDSTRDYN,
  // engine response
  input  logic [31:0] ENGRXD,
  input  logic [3:0]  ENGRXREM,
  input  logic        ENGRXSOFN,
  input  logic        ENGRXEOFN,
  input  logic        ENGRXSOPN,
  input  logic        ENGRXEOPN,
  input  logic        ENGRXSRCRDYN,
  output logic        ENGRXDSTRDYN,
  // requester RX, data/framing shared, handshake per channel
  output logic [31:0] CHRXD,
  output logic [3:0]  CHRXREM,
  output logic        CHRXSOFN,
  output logic        CHRXEOFN,
  output logic        CHRXSOPN,
  output logic        CHRXEOPN,
  output logic [1:0]  CHRXSRCRDYN,
  input  logic [1:0]  CHRXDSTRDYN,
  output logic [1:0]  GNT,
  output logic        TMO_ERR,
  output logic [1:0]  dbg_state_o
);

  localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

  arb_state_e  state_q;
  logic [1:0]  gnt_q;
  logic        last_q;
  logic [15:0] cnt_q;
  logic        tmo_q;

  logic [1:0]        req;
  logic [1:0]        arb_gnt;
  logic              sel;
  logic [LL_DW-1:0]  tx_d;
  logic [LL_RW-1:0]  tx_rem;
  logic              tx_src_n;
  logic              tx_sof_n;
  logic              tx_eof_n;
  logic              tx_sop_n;
  logic              tx_eop_n;
  logic              rx_dst_n;
  logic              tx_beat;
  logic              rx_beat;

  assign req = ~CHTXSRCRDYN & ~CHTXSOFN;

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Granted channel index; only meaningful outside IDLE.
  assign sel      = gnt_q[1];
  assign tx_d     = sel ? CHTXD[63:32] : CHTXD[31:0];
  assign tx_rem   = sel ? CHTXREM[7:4] : CHTXREM[3:0];
  assign tx_src_n = CHTXSRCRDYN[sel];
  assign tx_sof_n = CHTXSOFN[sel];
  assign tx_eof_n = CHTXEOFN[sel];
  assign tx_sop_n = CHTXSOPN[sel];
  assign tx_eop_n = CHTXEOPN[sel];
  assign rx_dst_n = CHRXDSTRDYN[sel];

  assign tx_beat = (state_q == ST_TX) && ll_beat(tx_src_n, ENGTXDSTRDYN);
  assign rx_beat = ((state_q == ST_WAIT) || (state_q == ST_RX)) &&
                   ll_beat(ENGRXSRCRDYN, rx_dst_n);

  always_ff @(posedge CPMDMALLCLK or posedge DMALLRSTENGINEACK) begin
    if (DMALLRSTENGINEACK) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q   <= arb_gnt;
            last_q  <= arb_gnt[1];
            state_q <= ST_TX;
          end
        end
        ST_TX: begin
          if (tx_beat && !tx_eof_n) begin
            cnt_q   <= 16'd0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response SOF on the last allowed cycle beats the timeout.
          if (rx_beat && !ENGRXSOFN) begin
            if (!ENGRXEOFN) begin
              gnt_q   <= 2'b00;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RX;
            end
          end else if (cnt_q == TMO_LAST) begin
            gnt_q   <= 2'b00;
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RX: begin
          if (rx_beat && !ENGRXEOFN) begin
            gnt_q   <= 2'b00;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    CHTXDSTRDYN  = 2'b11;
    ENGTXD       = '0;
    ENGTXREM     = '0;
    ENGTXSOFN    = 1'b1;
    ENGTXEOFN    = 1'b1;
    ENGTXSOPN    = 1'b1;
    ENGTXEOPN    = 1'b1;
    ENGTXSRCRDYN = 1'b1;
    CHRXD        = '0;
    CHRXREM      = '0;
    CHRXSOFN     = 1'b1;
    CHRXEOFN     = 1'b1;
    CHRXSOPN     = 1'b1;
    CHRXEOPN     = 1'b1;
    CHRXSRCRDYN  = 2'b11;
    ENGRXDSTRDYN = 1'b1;
    case (state_q)
      // Stray engine beats are drained while nobody owns the engine.
      ST_IDLE: ENGRXDSTRDYN = 1'b0;
      ST_TX: begin
        ENGTXD            = tx_d;
        ENGTXREM          = tx_rem;
        ENGTXSOFN         = tx_sof_n;
        ENGTXEOFN         = tx_eof_n;
        ENGTXSOPN         = tx_sop_n;
        ENGTXEOPN         = tx_eop_n;
        ENGTXSRCRDYN      = tx_src_n;
        CHTXDSTRDYN[sel]  = ENGTXDSTRDYN;
      end
      ST_WAIT, ST_RX: begin
        CHRXD             = ENGRXD;
        CHRXREM           = ENGRXREM;
        CHRXSOFN          = ENGRXSOFN;
        CHRXEOFN          = ENGRXEOFN;
        CHRXSOPN          = ENGRXSOPN;
        CHRXEOPN          = ENGRXEOPN;
        CHRXSRCRDYN[sel]  = ENGRXSRCRDYN;
        ENGRXDSTRDYN      = rx_dst_n;
      end
      default: ENGRXDSTRDYN = 1'b1;
    endcase
  end

  assign GNT         = gnt_q;
  assign TMO_ERR     = tmo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_comp_arb.sv
// Directed bench for comp_arb: a per-cycle vector table for arbitration and
// forwarding, plus hand sequences for back-pressure, timeout and reset.
module tb_comp_arb;
  import lzs_arb_pkg::*;

  localparam logic [15:0] TMO = 16'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] CHTXD;
  logic [7:0]  CHTXREM;
  logic [1:0]  CHTXSOFN, CHTXEOFN, CHTXSOPN, CHTXEOPN, CHTXSRCRDYN, CHTXDSTRDYN;
  logic [31:0] ENGTXD;
  logic [3:0]  ENGTXREM;
  logic        ENGTXSOFN, ENGTXEOFN, ENGTXSOPN, ENGTXEOPN, ENGTXSRCRDYN, ENGTXDSTRDYN;
  logic [31:0] ENGRXD;
  logic [3:0]  ENGRXREM;
  logic        ENGRXSOFN, ENGRXEOFN, ENGRXSOPN, ENGRXEOPN, ENGRXSRCRDYN, ENGRXDSTRDYN;
  logic [31:0] CHRXD;
  logic [3:0]  CHRXREM;
  logic        CHRXSOFN, CHRXEOFN, CHRXSOPN, CHRXEOPN;
  logic [1:0]  CHRXSRCRDYN, CHRXDSTRDYN;
  logic [1:0]  GNT;
  logic        TMO_ERR;
  logic [1:0]  dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  comp_arb #(.TIMEOUT_CYCLES(TMO)) dut (
    .CPMDMALLCLK(clk), .DMALLRSTENGINEACK(rst),
    .CHTXD(CHTXD), .CHTXREM(CHTXREM), .CHTXSOFN(CHTXSOFN), .CHTXEOFN(CHTXEOFN),
    .CHTXSOPN(CHTXSOPN), .CHTXEOPN(CHTXEOPN), .CHTXSRCRDYN(CHTXSRCRDYN),
    .CHTXDSTRDYN(CHTXDSTRDYN),
    .ENGTXD(ENGTXD), .ENGTXREM(ENGTXREM), .ENGTXSOFN(ENGTXSOFN), .ENGTXEOFN(ENGTXEOFN),
    .ENGTXSOPN(ENGTXSOPN), .ENGTXEOPN(ENGTXEOPN), .ENGTXSRCRDYN(ENGTXSRCRDYN),
    .ENGTXDSTRDYN(ENGTXDSTRDYN),
    .ENGRXD(ENGRXD), .ENGRXREM(ENGRXREM), .ENGRXSOFN(ENGRXSOFN), .ENGRXEOFN(ENGRXEOFN),
    .ENGRXSOPN(ENGRXSOPN), .ENGRXEOPN(ENGRXEOPN), .ENGRXSRCRDYN(ENGRXSRCRDYN),
    .ENGRXDSTRDYN(ENGRXDSTRDYN),
    .CHRXD(CHRXD), .CHRXREM(CHRXREM), .CHRXSOFN(CHRXSOFN), .CHRXEOFN(CHRXEOFN),
    .CHRXSOPN(CHRXSOPN), .CHRXEOPN(CHRXEOPN), .CHRXSRCRDYN(CHRXSRCRDYN),
    .CHRXDSTRDYN(CHRXDSTRDYN),
    .GNT(GNT), .TMO_ERR(TMO_ERR), .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [1:0] src, sof, eof;
    logic       etd, ers, erf, ere;
    logic [1:0] crd;
    logic [1:0] gnt, ctd;
    logic       ets, erd;
    logic [1:0] crs;
    logic       eso, eeo;
    logic [1:0] st, dsel;
    logic       rsel;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];

  function automatic vec_t mk(
    input logic [1:0] src, sof, eof, input logic etd, ers, erf, ere, input logic [1:0] crd,
    input logic [1:0] gnt, ctd, input logic ets, erd, input logic [1:0] crs,
    input logic eso, eeo, input logic [1:0] st, dsel, input logic rsel);
    vec_t v;
    v.src = src; v.sof = sof; v.eof = eof; v.etd = etd; v.ers = ers; v.erf = erf;
    v.ere = ere; v.crd = crd; v.gnt = gnt; v.ctd = ctd; v.ets = ets; v.erd = erd;
    v.crs = crs; v.eso = eso; v.eeo = eeo; v.st = st; v.dsel = dsel; v.rsel = rsel;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive_idle();
    CHTXD = '0; CHTXREM = 8'hC3;
    CHTXSRCRDYN = 2'b11; CHTXSOFN = 2'b11; CHTXEOFN = 2'b11;
    CHTXSOPN = 2'b11; CHTXEOPN = 2'b11; ENGTXDSTRDYN = 1'b0;
    ENGRXD = '0; ENGRXREM = 4'h5; ENGRXSRCRDYN = 1'b1;
    ENGRXSOFN = 1'b1; ENGRXEOFN = 1'b1; ENGRXSOPN = 1'b1; ENGRXEOPN = 1'b1;
    CHRXDSTRDYN = 2'b00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, GNT, 2'b00);
    chk({tag, "_tmo"}, TMO_ERR, 1'b0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
    chk({tag, "_chtxdst"}, CHTXDSTRDYN, 2'b11);
    chk({tag, "_chrxsrc"}, CHRXSRCRDYN, 2'b11);
    chk({tag, "_engtxsrc"}, ENGTXSRCRDYN, 1'b1);
    chk({tag, "_engrxdst"}, ENGRXDSTRDYN, 1'b0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] bp_data[4];
  logic [31:0] exp_d;
  logic [3:0]  exp_rem;
  logic        etd;
  int          idx, tx_cyc;

  initial begin
    // both channels single-beat from reset, then ch0-only 4-beat job
    tbl[0]  = mk(2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b1,2'b00, 2'b00,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_IDLE,2'd0,1'b0);
    tbl[1]  = mk(2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b1,2'b00, 2'b01,2'b10,1'b0,1'b1,2'b11,1'b0,1'b0,ST_TX,  2'd1,1'b0);
    tbl[2]  = mk(2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b01,2'b11,1'b1,1'b0,2'b10,1'b1,1'b1,ST_WAIT,2'd0,1'b1);
    tbl[3]  = mk(2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b1,2'b00, 2'b00,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_IDLE,2'd0,1'b0);
    tbl[4]  = mk(2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b1,2'b00, 2'b10,2'b01,1'b0,1'b1,2'b11,1'b0,1'b0,ST_TX,  2'd2,1'b0);
    tbl[5]  = mk(2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b10,2'b11,1'b1,1'b0,2'b01,1'b1,1'b1,ST_WAIT,2'd0,1'b1);
    tbl[6]  = mk(2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b1,2'b00, 2'b00,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_IDLE,2'd0,1'b0);
    tbl[7]  = mk(2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b1,2'b00, 2'b01,2'b10,1'b0,1'b1,2'b11,1'b0,1'b0,ST_TX,  2'd1,1'b0);
    tbl[8]  = mk(2'b11,2'b11,2'b11,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b01,2'b11,1'b1,1'b0,2'b10,1'b1,1'b1,ST_WAIT,2'd0,1'b1);
    tbl[9]  = mk(2'b11,2'b11,2'b11,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_IDLE,2'd0,1'b0);
    tbl[10] = mk(2'b10,2'b10,2'b11,1'b0,1'b1,1'b1,1'b1,2'b10, 2'b00,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_IDLE,2'd0,1'b0);
    tbl[11] = mk(2'b10,2'b10,2'b11,1'b0,1'b1,1'b1,1'b1,2'b10, 2'b01,2'b10,1'b0,1'b1,2'b11,1'b0,1'b1,ST_TX,  2'd1,1'b0);
    tbl[12] = mk(2'b10,2'b11,2'b11,1'b0,1'b1,1'b1,1'b1,2'b10, 2'b01,2'b10,1'b0,1'b1,2'b11,1'b1,1'b1,ST_TX,  2'd1,1'b0);
    tbl[13] = mk(2'b10,2'b11,2'b11,1'b1,1'b1,1'b1,1'b1,2'b10, 2'b01,2'b11,1'b0,1'b1,2'b11,1'b1,1'b1,ST_TX,  2'd1,1'b0);
    tbl[14] = mk(2'b10,2'b11,2'b11,1'b0,1'b1,1'b1,1'b1,2'b10, 2'b01,2'b10,1'b0,1'b1,2'b11,1'b1,1'b1,ST_TX,  2'd1,1'b0);
    tbl[15] = mk(2'b10,2'b11,2'b10,1'b0,1'b1,1'b1,1'b1,2'b10, 2'b01,2'b10,1'b0,1'b1,2'b11,1'b1,1'b0,ST_TX,  2'd1,1'b0);
    tbl[16] = mk(2'b11,2'b11,2'b11,1'b0,1'b1,1'b1,1'b1,2'b10, 2'b01,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_WAIT,2'd0,1'b1);
    tbl[17] = mk(2'b11,2'b11,2'b11,1'b0,1'b1,1'b1,1'b1,2'b10, 2'b01,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_WAIT,2'd0,1'b1);
    tbl[18] = mk(2'b11,2'b11,2'b11,1'b0,1'b0,1'b0,1'b1,2'b10, 2'b01,2'b11,1'b1,1'b0,2'b10,1'b1,1'b1,ST_WAIT,2'd0,1'b1);
    tbl[19] = mk(2'b11,2'b11,2'b11,1'b0,1'b0,1'b1,1'b0,2'b10, 2'b01,2'b11,1'b1,1'b0,2'b10,1'b1,1'b1,ST_RX,  2'd0,1'b1);
    tbl[20] = mk(2'b11,2'b11,2'b11,1'b0,1'b1,1'b1,1'b1,2'b00, 2'b00,2'b11,1'b1,1'b0,2'b11,1'b1,1'b1,ST_IDLE,2'd0,1'b0);

    // clock/reset
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("por");
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      CHTXSRCRDYN = tbl[k].src; CHTXSOFN = tbl[k].sof; CHTXEOFN = tbl[k].eof;
      CHTXSOPN = tbl[k].sof; CHTXEOPN = tbl[k].eof; ENGTXDSTRDYN = tbl[k].etd;
      CHTXD = {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
      ENGRXSRCRDYN = tbl[k].ers; ENGRXSOFN = tbl[k].erf; ENGRXEOFN = tbl[k].ere;
      ENGRXSOPN = tbl[k].erf; ENGRXEOPN = tbl[k].ere; CHRXDSTRDYN = tbl[k].crd;
      ENGRXD = 32'hE000_0000 + 32'(k);
      case (tbl[k].dsel)
        2'd1:    begin exp_d = 32'hA000_0000 + 32'(k); exp_rem = 4'h3; end
        2'd2:    begin exp_d = 32'hB000_0000 + 32'(k); exp_rem = 4'hC; end
        default: begin exp_d = 32'h0; exp_rem = 4'h0; end
      endcase
      #1;
      chk($sformatf("gnt[%0d]", k), GNT, tbl[k].gnt);
      chk($sformatf("state[%0d]", k), dbg_state, tbl[k].st);
      chk($sformatf("chtxdst[%0d]", k), CHTXDSTRDYN, tbl[k].ctd);
      chk($sformatf("engtxsrc[%0d]", k), ENGTXSRCRDYN, tbl[k].ets);
      chk($sformatf("engrxdst[%0d]", k), ENGRXDSTRDYN, tbl[k].erd);
      chk($sformatf("chrxsrc[%0d]", k), CHRXSRCRDYN, tbl[k].crs);
      chk($sformatf("engtxsof[%0d]", k), ENGTXSOFN, tbl[k].eso);
      chk($sformatf("engtxeof[%0d]", k), ENGTXEOFN, tbl[k].eeo);
      chk($sformatf("engtxd[%0d]", k), ENGTXD, exp_d);
      chk($sformatf("engtxrem[%0d]", k), ENGTXREM, exp_rem);
      chk($sformatf("chrxd[%0d]", k), CHRXD, tbl[k].rsel ? 32'hE000_0000 + 32'(k) : 32'h0);
      chk($sformatf("tmo[%0d]", k), TMO_ERR, 1'b0);
    end

    // ch1 4-beat frame with a 5-cycle engine stall after the second beat
    bp_data[0] = 32'h1111_0000; bp_data[1] = 32'h2222_0001;
    bp_data[2] = 32'h3333_0002; bp_data[3] = 32'h4444_0003;
    for (int i = 0; i < 4; i++) exp_q.push_back(bp_data[i]);
    drive_idle();
    idx = 0; tx_cyc = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(negedge clk);
      CHTXSRCRDYN = 2'b01;
      CHTXSOFN = {idx != 0, 1'b1};
      CHTXEOFN = {idx != 3, 1'b1};
      CHTXD[63:32] = bp_data[idx];
      etd = (tx_cyc >= 2 && tx_cyc <= 6);
      ENGTXDSTRDYN = etd;
      #1;
      if (dbg_state == ST_TX) begin
        chk($sformatf("bp_ready[%0d]", tx_cyc), CHTXDSTRDYN, {etd, 1'b1});
        tx_cyc++;
      end
      if (!ENGTXSRCRDYN && !ENGTXDSTRDYN) begin
        chk($sformatf("bp_data[%0d]", idx), ENGTXD, exp_q.pop_front());
        idx++;
      end
    end
    chk("bp_beats", idx, 4);
    chk("bp_q_empty", exp_q.size(), 0);
    chk("bp_tx_cycles", tx_cyc, 9);
    @(negedge clk);
    drive_idle();
    ENGRXSRCRDYN = 1'b0; ENGRXSOFN = 1'b0; ENGRXEOFN = 1'b0;
    #1;
    chk("bp_wait", dbg_state, ST_WAIT);
    chk("bp_chrxsrc", CHRXSRCRDYN, 2'b01);
    @(negedge clk);
    drive_idle();
    #1;
    chk("bp_done_gnt", GNT, 2'b00);
    chk("bp_done_state", dbg_state, ST_IDLE);

    // ch0 job with a silent engine; ch1 queues behind it
    @(negedge clk);
    CHTXSRCRDYN = 2'b10; CHTXSOFN = 2'b10; CHTXEOFN = 2'b10;
    #1 chk("to_idle", dbg_state, ST_IDLE);
    @(negedge clk);
    #1;
    chk("to_tx", dbg_state, ST_TX);
    chk("to_gnt", GNT, 2'b01);
    @(negedge clk);
    CHTXSRCRDYN = 2'b01; CHTXSOFN = 2'b01; CHTXEOFN = 2'b11;
    for (int w = 0; w < 8; w++) begin
      if (w > 0) @(negedge clk);
      #1;
      chk($sformatf("to_wait[%0d]", w), dbg_state, ST_WAIT);
      chk($sformatf("to_nopulse[%0d]", w), TMO_ERR, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("to_pulse", TMO_ERR, 1'b1);
    chk("to_gnt_clr", GNT, 2'b00);
    chk("to_state", dbg_state, ST_IDLE);
    @(negedge clk);
    #1;
    chk("to_pulse_end", TMO_ERR, 1'b0);
    chk("to_next_gnt", GNT, 2'b10);
    chk("to_next_state", dbg_state, ST_TX);

    // reset pulse during the second TX beat of ch1
    @(negedge clk);
    CHTXSOFN = 2'b11;
    #1;
    chk("rst_pre_tx", ENGTXSRCRDYN, 1'b0);
    rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    #1 rst = 1'b0;
    CHTXSOFN = 2'b01;
    @(negedge clk);
    #1;
    chk("rst_regnt", GNT, 2'b10);
    chk("rst_regnt_state", dbg_state, ST_TX);
    chk("rst_regnt_ready", CHTXDSTRDYN, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
